image_feeder: RTL and testbench
===============================

Name: image_feeder

Overview:
- Upstream stage of the CONV convolution engine.
- Accepts one 64x64 frame of 20-bit signed fixed-point pixels (4-bit integer, 16-bit fraction) over a valid/ready stream and stores it in a 4096-entry buffer.
- Hands the frame to CONV via the ready/busy handshake, then serves CONV's iaddr→idata read port until CONV finishes.
- Reports completion; the next frame can then be loaded.

Parameters:
- PIX_W, 20, pixel width in bits.
- ADDR_W, 12, pixel address width (raster order, addr = row*64 + col).
- NPIX, 4096, pixels per frame.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  block can accept a pixel.
- s_data  in  PIX_W  pixel value.
- s_last  in  1  marks the final pixel of a frame.
- ready  out  1  frame-available request to CONV.
- busy  in  1  CONV busy.
- iaddr  in  ADDR_W  CONV pixel read address.
- idata  out  PIX_W  pixel at iaddr.
- done  out  1  one-cycle pulse when CONV has finished the frame.
- err_len  out  1  one-cycle pulse on a frame-length violation.
- frame_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - state=LOAD, wr_ptr=0; s_ready, ready, done, err_len and frame_cnt all 0.
  - Buffer contents are not reset and are don't-care.
  - Reset mid-frame or mid-run aborts immediately; the partial frame is discarded.
- Read port:
  - idata = buf[iaddr], combinational in all states with no register; CONV registers it internally.
  - Buffer writes never coincide with a CONV run, because s_ready=0 outside LOAD.
- State LOAD:
  - s_ready=1 (registered; becomes 1 the cycle after entering LOAD, including the first cycle after reset release).
  - On s_valid&s_ready: buf[wr_ptr]<=s_data, wr_ptr<=wr_ptr+1.
  - Accept with s_last=1 and wr_ptr==NPIX-1: frame complete; wr_ptr<=0, go to ARM, s_ready<=0.
  - Accept with s_last=1 and wr_ptr<NPIX-1 (short frame): err_len pulses next cycle, wr_ptr<=0, stay in LOAD, frame discarded.
  - Accept with s_last=0 and wr_ptr==NPIX-1 (long frame or missing last): pixel stored, frame treated as complete, err_len pulses, go to ARM.
  - Pixels offered after completion see s_ready=0 and are not accepted.
- State ARM:
  - ready=1, held until busy is sampled high, then ready<=0 and go to RUN.
  - No timeout; ready stays high indefinitely if busy never rises.
  - If busy is already high on ARM entry (previous run still draining), stay in ARM until busy has been seen low for at least one cycle and then rises again.
- State RUN:
  - ready=0, s_ready=0.
  - On busy sampled low: done<=1 for exactly one cycle, frame_cnt<=frame_cnt+1, go to LOAD.
  - s_ready rises the cycle after done.
- State transitions are registered; all outputs except idata are registered.
- Latency:
  - Last pixel accepted to ready high: 1 cycle.
  - busy falling to done pulse: 1 cycle.
- Simultaneous events:
  - s_valid during ARM/RUN is ignored; it is upstream's responsibility to hold its data.
  - done and err_len never assert in the same cycle.

Test Plan:
- Reset then 4096 pixels with s_data=addr (s_last on pixel 4095) → ready=1 one cycle after the last accept; for iaddr=0, 63, 4095, idata=0, 63, 4095.
- Handshake: hold busy=0 for 5 cycles after ready → ready stays 1; raise busy → ready falls next cycle; drop busy after 100 cycles → done pulses once, frame_cnt=1, s_ready=1 the following cycle.
- Short frame: s_last on pixel 10 → err_len pulse, state stays LOAD, wr_ptr=0; a following correct 4096-pixel frame → ready asserts, buf[0] holds the new frame's first pixel.
- Long frame: 4096 pixels with s_last never set → err_len pulse, ready asserts; a 4097th s_valid is not accepted (s_ready=0).
- Backpressure/gaps: random s_valid gaps across a full frame → all 4096 values read back correctly via iaddr sweep.
- Async reset asserted during RUN with busy=1 → ready=0, s_ready=1 after release, frame_cnt=0, no done pulse; 256 consecutive frames → frame_cnt wraps to 0.

Source files
------------

// File: rtl/image_feeder.sv
// Frame buffer feeding the CONV engine: loads one frame over a valid/ready stream,
// hands it to CONV via ready/busy and serves CONV's combinational iaddr->idata port.
`timescale 1ns/1ps

module image_feeder #(
  parameter int PIX_W  = 20,
  parameter int ADDR_W = 12,
  parameter int NPIX   = 4096,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [PIX_W-1:0]  idata,
  output logic              done,
  output logic              err_len,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr,    w_wr_ptr_nxt;
  logic              r_s_ready,   w_s_ready_nxt;
  logic              r_ready,     w_ready_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_err_len,   w_err_len_nxt;
  logic              r_busy_low,  w_busy_low_nxt;
  logic [CNT_W-1:0]  r_frame_cnt, w_frame_cnt_nxt;

  logic [PIX_W-1:0]  r_buf [NPIX];

  logic w_accept;
  logic w_at_end;

  assign w_accept = (r_state == LOAD) && r_s_ready && s_valid;
  assign w_at_end = (r_wr_ptr == LAST_ADDR);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_s_ready_nxt   = 1'b0;
    w_ready_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_len_nxt   = 1'b0;
    w_busy_low_nxt  = r_busy_low;
    w_frame_cnt_nxt = r_frame_cnt;

    case (r_state)
      LOAD: begin
        w_s_ready_nxt = 1'b1;
        if (w_accept) begin
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          if (w_at_end) begin
            // A full frame is kept even without s_last; the missing marker is flagged.
            w_state_nxt    = ARM;
            w_wr_ptr_nxt   = '0;
            w_s_ready_nxt  = 1'b0;
            w_ready_nxt    = 1'b1;
            w_busy_low_nxt = 1'b0;
            w_err_len_nxt  = ~s_last;
          end else if (s_last) begin
            w_wr_ptr_nxt  = '0;
            w_err_len_nxt = 1'b1;
          end
        end
      end

      ARM: begin
        w_ready_nxt = 1'b1;
        // A busy already high on entry belongs to the previous run; wait for a low first.
        if (!busy) begin
          w_busy_low_nxt = 1'b1;
        end else if (r_busy_low) begin
          w_state_nxt = RUN;
          w_ready_nxt = 1'b0;
        end
      end

      RUN: begin
        if (!busy) begin
          w_state_nxt     = LOAD;
          w_done_nxt      = 1'b1;
          w_frame_cnt_nxt = r_frame_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_wr_ptr    <= '0;
      r_s_ready   <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_err_len   <= 1'b0;
      r_busy_low  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_err_len   <= w_err_len_nxt;
      r_busy_low  <= w_busy_low_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // NOTE: the pixel buffer has no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= s_data;
    end
  end

  assign idata     = r_buf[iaddr];
  assign s_ready   = r_s_ready;
  assign ready     = r_ready;
  assign done      = r_done;
  assign err_len   = r_err_len;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_image_feeder.sv
// Directed bench for image_feeder: full 64x64 DUT for load/handshake/length/reset cases,
// plus a 16-pixel instance to exercise frame counter wrap in few cycles.
`timescale 1ns/1ps

module tb_image_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] s_data;
  logic        s_last;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        done;
  logic        err_len;
  logic [7:0]  frame_cnt;

  logic        m_reset;
  logic        m_valid;
  logic        m_s_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        m_busy;
  logic [3:0]  m_iaddr;
  logic [7:0]  m_idata;
  logic        m_done;
  logic        m_err_len;
  logic [7:0]  m_frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  image_feeder u_dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .done      (done),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  image_feeder #(.PIX_W(8), .ADDR_W(4), .NPIX(16), .CNT_W(8)) u_small (
    .clk       (clk),
    .reset     (m_reset),
    .s_valid   (m_valid),
    .s_ready   (m_s_ready),
    .s_data    (m_data),
    .s_last    (m_last),
    .ready     (m_ready),
    .busy      (m_busy),
    .iaddr     (m_iaddr),
    .idata     (m_idata),
    .done      (m_done),
    .err_len   (m_err_len),
    .frame_cnt (m_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: timed out waiting for s_ready, expected accept within 50 cycles", tag);
  endtask

  // Offer one pixel after 'gap' idle cycles; returns after the edge that accepted it.
  task automatic push(input logic [19:0] d, input logic l, input int gap);
    logic took;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int k = 0; k < 50; k++) begin
      took = s_ready;
      tick();
      if (took) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    timeout("push");
  endtask

  task automatic push_small(input logic [7:0] d, input logic l);
    logic took;
    m_valid = 1'b1;
    m_data  = d;
    m_last  = l;
    for (int k = 0; k < 50; k++) begin
      took = m_s_ready;
      tick();
      if (took) begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        return;
      end
    end
    m_valid = 1'b0;
    m_last  = 1'b0;
    timeout("push_small");
  endtask

  task automatic read_chk(input string tag, input logic [11:0] a, input logic [19:0] exp);
    iaddr = a;
    #1;
    check(tag, 32'(idata), 32'(exp));
  endtask

  // Full CONV run: one low cycle in ARM, busy high for 1+hold cycles, then busy low.
  task automatic run_conv(input int hold);
    busy = 1'b0;
    tick();
    busy = 1'b1;
    tick();
    repeat (hold) tick();
    busy = 1'b0;
    tick();
  endtask

  task automatic small_frame();
    for (int p = 0; p < 16; p++) push_small(8'(p), p == 15);
    m_busy = 1'b0;
    tick();
    m_busy = 1'b1;
    tick();
    m_busy = 1'b0;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    m_reset = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    busy    = 1'b0;
    iaddr   = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_busy  = 1'b0;
    m_iaddr = '0;

    // Reset state
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset   = 1'b0;
    m_reset = 1'b0;
    #1;
    check("rel_s_ready_low", 32'(s_ready), 32'd0);
    tick();
    check("rel_s_ready_high", 32'(s_ready), 32'd1);

    // Frame 1: data = address
    for (int i = 0; i < 4096; i++) push(20'(i), i == 4095, 0);
    check("f1_ready", 32'(ready), 32'd1);
    check("f1_s_ready", 32'(s_ready), 32'd0);
    check("f1_err_len", 32'(err_len), 32'd0);
    read_chk("f1_rd0", 12'd0, 20'd0);
    read_chk("f1_rd63", 12'd63, 20'd63);
    read_chk("f1_rd4095", 12'd4095, 20'd4095);

    // Handshake
    busy = 1'b0;
    repeat (5) tick();
    check("hs_ready_hold", 32'(ready), 32'd1);
    busy = 1'b1;
    tick();
    check("hs_ready_fall", 32'(ready), 32'd0);
    repeat (99) tick();
    check("hs_run_no_done", 32'(done), 32'd0);
    check("hs_run_s_ready", 32'(s_ready), 32'd0);
    busy = 1'b0;
    tick();
    check("hs_done", 32'(done), 32'd1);
    check("hs_frame_cnt", 32'(frame_cnt), 32'd1);
    check("hs_s_ready_with_done", 32'(s_ready), 32'd0);
    tick();
    check("hs_done_one_cycle", 32'(done), 32'd0);
    check("hs_s_ready_after", 32'(s_ready), 32'd1);

    // Short frame: s_last on pixel index 10
    for (int i = 0; i < 11; i++) push(20'(100 + i), i == 10, 0);
    check("sf_err_len", 32'(err_len), 32'd1);
    check("sf_ready", 32'(ready), 32'd0);
    check("sf_s_ready", 32'(s_ready), 32'd1);
    tick();
    check("sf_err_len_pulse", 32'(err_len), 32'd0);
    for (int i = 0; i < 4096; i++) push(20'h10000 + 20'(i), i == 4095, 0);
    check("sf2_ready", 32'(ready), 32'd1);
    check("sf2_err_len", 32'(err_len), 32'd0);
    read_chk("sf2_rd0", 12'd0, 20'h10000);
    read_chk("sf2_rd10", 12'd10, 20'h1000A);
    read_chk("sf2_rd4095", 12'd4095, 20'h10FFF);
    run_conv(3);
    check("sf2_done", 32'(done), 32'd1);
    check("sf2_frame_cnt", 32'(frame_cnt), 32'd2);
    tick();

    // Long frame with busy still high from a previous run
    busy = 1'b1;
    for (int i = 0; i < 4096; i++) push(20'hFFFFF - 20'(i), 1'b0, 0);
    check("lf_err_len", 32'(err_len), 32'd1);
    check("lf_ready", 32'(ready), 32'd1);
    check("lf_done_clear", 32'(done), 32'd0);
    s_valid = 1'b1;
    s_data  = 20'h12345;
    s_last  = 1'b1;
    #1;
    check("lf_extra_s_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("lf_err_len_pulse", 32'(err_len), 32'd0);
    read_chk("lf_rd0", 12'd0, 20'hFFFFF);
    read_chk("lf_rd4095", 12'd4095, 20'hFF000);
    repeat (2) tick();
    check("lf_ready_busy_stale", 32'(ready), 32'd1);
    busy = 1'b0;
    tick();
    check("lf_ready_busy_low", 32'(ready), 32'd1);
    busy = 1'b1;
    tick();
    check("lf_ready_fall", 32'(ready), 32'd0);
    busy = 1'b0;
    tick();
    check("lf_done", 32'(done), 32'd1);
    check("lf_frame_cnt", 32'(frame_cnt), 32'd3);
    tick();

    // Gapped stream, full read-back
    for (int i = 0; i < 4096; i++) begin
      push(20'(i * 13 + 5), i == 4095, (i % 5 == 3) ? 2 : ((i % 7 == 0) ? 1 : 0));
    end
    check("gp_ready", 32'(ready), 32'd1);
    for (int a = 0; a < 4096; a++) begin
      read_chk($sformatf("gp_rd[%0d]", a), 12'(a), 20'(a * 13 + 5));
    end

    // Async reset in RUN
    busy = 1'b0;
    tick();
    busy = 1'b1;
    tick();
    check("rr_in_run_ready", 32'(ready), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rr_frame_cnt_async", 32'(frame_cnt), 32'd0);
    check("rr_s_ready_async", 32'(s_ready), 32'd0);
    busy = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rr_done_rel", 32'(done), 32'd0);
    tick();
    check("rr_s_ready", 32'(s_ready), 32'd1);
    check("rr_ready", 32'(ready), 32'd0);
    check("rr_done", 32'(done), 32'd0);
    check("rr_frame_cnt", 32'(frame_cnt), 32'd0);

    // Frame counter wrap on the 16-pixel instance
    for (int f = 0; f < 256; f++) begin
      small_frame();
      if (f == 0) check("wr_cnt_1", 32'(m_frame_cnt), 32'd1);
      if (f == 254) check("wr_cnt_255", 32'(m_frame_cnt), 32'd255);
    end
    check("wr_done", 32'(m_done), 32'd1);
    check("wr_cnt_wrap", 32'(m_frame_cnt), 32'd0);
    m_iaddr = 4'd15;
    #1;
    check("wr_rd15", 32'(m_idata), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
